// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler: round-robin arbiter sharing the time base and slot timestamp table among gates
module parking_gate_scheduler #(
    parameter int NUM_GATES = 4,
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  time_value,
    input  logic [NUM_GATES-1:0]        req,
    input  logic [NUM_GATES-1:0]        req_exit,
    input  logic [NUM_GATES*SLOT_W-1:0] req_slot,
    output logic [NUM_GATES-1:0]        grant,
    output logic                        resp_valid,
    output logic [2:0]                  resp_gate,
    output logic                        resp_exit,
    output logic [7:0]                  resp_duration,
    output logic                        resp_err,
    output logic [NUM_SLOTS-1:0]        occupied,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t               state_q, state_d;
    logic [2:0]           ptr_q, ptr_d, gate_q, gate_d, win;
    logic                 exit_q, exit_d, win_exit;
    logic [SLOT_W-1:0]    slot_q, slot_d, win_slot;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [2:0]           resp_gate_q, resp_gate_d;
    logic                 resp_exit_q, resp_exit_d, resp_err_q, resp_err_d;
    logic [7:0]           resp_dur_q, resp_dur_d;
    logic [7:0]           tbl_q [NUM_SLOTS];
    logic                 slot_ok, hit;
    logic [7:0]           stamp;

    // Lowest requester overall, then overridden by the lowest one at or above the pointer.
    always_comb begin
        win      = 3'd0;
        win_exit = 1'b0;
        win_slot = '0;
        for (int g = NUM_GATES - 1; g >= 0; g--)
            if (req[g]) begin
                win      = 3'(g);
                win_exit = req_exit[g];
                win_slot = req_slot[g*SLOT_W +: SLOT_W];
            end
        for (int g = NUM_GATES - 1; g >= 0; g--)
            if (req[g] && g >= int'(ptr_q)) begin
                win      = 3'(g);
                win_exit = req_exit[g];
                win_slot = req_slot[g*SLOT_W +: SLOT_W];
            end
    end

    always_comb begin
        slot_ok = int'(slot_q) < NUM_SLOTS;
        hit     = 1'b0;
        stamp   = 8'd0;
        for (int s = 0; s < NUM_SLOTS; s++)
            if (int'(slot_q) == s) begin
                hit   = occ_q[s];
                stamp = tbl_q[s];
            end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gate_d      = gate_q;
        exit_d      = exit_q;
        slot_d      = slot_q;
        occ_d       = occ_q;
        resp_gate_d = resp_gate_q;
        resp_exit_d = resp_exit_q;
        resp_dur_d  = resp_dur_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = EXEC;
                gate_d  = win;
                exit_d  = win_exit;
                slot_d  = win_slot;
                ptr_d   = (win == 3'(NUM_GATES - 1)) ? 3'd0 : win + 3'd1;
            end
            EXEC: begin
                state_d     = RESP;
                resp_gate_d = gate_q;
                resp_exit_d = exit_q;
                resp_err_d  = !slot_ok || (exit_q ? !hit : hit);
                resp_dur_d  = (slot_ok && exit_q && hit) ? time_value - stamp : 8'd0;
                // Entry into a free slot sets it, exit from an occupied slot clears it.
                if (slot_ok && (exit_q == hit))
                    for (int s = 0; s < NUM_SLOTS; s++)
                        if (int'(slot_q) == s) occ_d[s] = !exit_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            gate_q      <= 3'd0;
            exit_q      <= 1'b0;
            slot_q      <= '0;
            occ_q       <= '0;
            resp_gate_q <= 3'd0;
            resp_exit_q <= 1'b0;
            resp_dur_q  <= 8'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gate_q      <= gate_d;
            exit_q      <= exit_d;
            slot_q      <= slot_d;
            occ_q       <= occ_d;
            resp_gate_q <= resp_gate_d;
            resp_exit_q <= resp_exit_d;
            resp_dur_q  <= resp_dur_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == EXEC && !exit_q && slot_ok && !hit)
            for (int s = 0; s < NUM_SLOTS; s++)
                if (int'(slot_q) == s) tbl_q[s] <= time_value;
    end

    assign grant         = (state_q == EXEC) ? NUM_GATES'(1) << gate_q : '0;
    assign resp_valid    = state_q == RESP;
    assign busy          = state_q != IDLE;
    assign occupied      = occ_q;
    assign resp_gate     = resp_gate_q;
    assign resp_exit     = resp_exit_q;
    assign resp_duration = resp_dur_q;
    assign resp_err      = resp_err_q;
endmodule
